seq_detect_scheduler: RTL and testbench

Time-shares a single "1011" serial pattern-detect step among NUM_LANES serial bit lanes. A round-robin arbiter grants one lane per cycle. The granted bit advances that lane's saved 2-bit detector context, and a match is reported with its lane ID. The block sits between the serial front-end lanes and the event/status logic, and replaces per-lane detector instances.

---
 rtl/seq_sched_pkg.sv | 44 ++++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/seq_detect_scheduler.sv | 86 ++++++++
 tb/tb_seq_detect_scheduler.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seq_sched_pkg.sv
// Shared types and the per-bit "1011" detector step used by seq_detect_scheduler.
//   ctx_t     : 2-bit detector context (S0 none, S1 "1", S2 "10", S3 "101")
//   step_t    : next context plus match flag returned by next_ctx
//   next_ctx  : pure transition function for one consumed bit
package seq_sched_pkg;

  localparam int NUM_LANES_DEF = 4;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } ctx_t;

  typedef struct packed {
    ctx_t nxt;
    logic hit;
  } step_t;

  function automatic step_t next_ctx(input ctx_t cur, input logic b, input logic ovl);
    step_t r;
    r.nxt = S0;
    r.hit = 1'b0;
    case (cur)
      S0: r.nxt = b ? S1 : S0;
      S1: r.nxt = b ? S1 : S2;
      S2: r.nxt = b ? S3 : S0;
      S3: begin
        if (b) begin
          r.hit = 1'b1;
          // Overlapping mode keeps the trailing "1" as a fresh prefix.
          r.nxt = ovl ? S1 : S0;
        end else begin
          r.nxt = S2;
        end
      end
      default: r.nxt = S0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered search pointer.
//   clk, reset_n : clock, synchronous active-low reset (pointer -> 0)
//   req          : N request lines
//   adv          : move the pointer past the granted index on this edge
//   clr_mask     : force all grants low (pointer holds)
//   gnt          : one-hot grant, combinational
//   gnt_idx      : binary index of the grant (0 when no grant)
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  input  logic          clr_mask,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] j;
  logic          found;

  // Search upward from ptr with wrap; first requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((32'(ptr) + k) % N);
      if (!found && !clr_mask && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = j;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (adv && found) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Time-shared "1011" serial detector serving NUM_LANES bit lanes.
// One lane per cycle is granted round-robin; its saved context advances by
// the granted bit and a match is reported with the lane index.
//   clk, reset_n : clock, synchronous active-low reset
//   lane_valid   : per-lane bit available
//   lane_bit     : per-lane serial bit, used only for the granted lane
//   lane_en      : per-lane enable; a disabled lane is held in S0
//   overlap      : 1 = overlapping detection, 0 = non-overlapping
//   clear_ctx    : clear all contexts, suppress grants this cycle
//   lane_ready   : one-hot grant (combinational)
//   match_valid  : registered one-cycle match pulse
//   match_lane   : lane of the last match
//   match_count  : saturating total of matches
module seq_detect_scheduler
  import seq_sched_pkg::*;
#(
  parameter  int NUM_LANES = NUM_LANES_DEF,
  parameter  int CNT_W     = CNT_W_DEF,
  localparam int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_LANES-1:0] lane_valid,
  input  logic [NUM_LANES-1:0] lane_bit,
  input  logic [NUM_LANES-1:0] lane_en,
  input  logic                 overlap,
  input  logic                 clear_ctx,
  output logic [NUM_LANES-1:0] lane_ready,
  output logic                 match_valid,
  output logic [LANE_W-1:0]    match_lane,
  output logic [CNT_W-1:0]     match_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NUM_LANES-1:0] req;
  logic [LANE_W-1:0]    gnt_idx;
  logic                 xfer;
  step_t                step;
  ctx_t                 ctx [NUM_LANES];

  // Reset also masks grants so nothing looks ready while reset_n is low.
  assign req  = lane_valid & lane_en;
  assign xfer = |lane_ready;

  rr_arbiter #(.N(NUM_LANES)) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .adv      (xfer),
    .clr_mask (clear_ctx | ~reset_n),
    .gnt      (lane_ready),
    .gnt_idx  (gnt_idx)
  );

  always_comb begin
    step = next_ctx(ctx[gnt_idx], lane_bit[gnt_idx], overlap);
  end

  // Stage boundary: context update and match outputs register on the consuming edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LANES; i++) ctx[i] <= S0;
      match_valid <= 1'b0;
      match_lane  <= '0;
      match_count <= '0;
    end else begin
      match_valid <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (clear_ctx || !lane_en[i]) begin
          ctx[i] <= S0;
        end else if (lane_ready[i]) begin
          ctx[i] <= step.nxt;
        end
      end
      if (xfer && step.hit) begin
        match_valid <= 1'b1;
        match_lane  <= gnt_idx;
        match_count <= sat_inc(match_count);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler (NUM_LANES=4, CNT_W=4 so that
// counter saturation at 15 is reachable in a short run).
module tb_seq_detect_scheduler;

  localparam int NL = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NL-1:0] lane_valid;
  logic [NL-1:0] lane_bit;
  logic [NL-1:0] lane_en;
  logic          overlap;
  logic          clear_ctx;
  logic [NL-1:0] lane_ready;
  logic          match_valid;
  logic [1:0]    match_lane;
  logic [CW-1:0] match_count;

  int total = 0;
  int bad   = 0;

  seq_detect_scheduler #(.NUM_LANES(NL), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .lane_valid  (lane_valid),
    .lane_bit    (lane_bit),
    .lane_en     (lane_en),
    .overlap     (overlap),
    .clear_ctx   (clear_ctx),
    .lane_ready  (lane_ready),
    .match_valid (match_valid),
    .match_lane  (match_lane),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer on a single enabled lane; other lanes carry the inverse bit.
  task automatic feed(input int lane, input logic b, input logic exp_hit);
    logic [NL-1:0] oh;
    oh         = NL'(1) << lane;
    lane_valid = oh;
    lane_en    = oh;
    lane_bit   = b ? oh : ~oh;
    clear_ctx  = 1'b0;
    #1;
    chk("feed_ready", 32'(lane_ready), 32'(oh));
    @(posedge clk); #1;
    chk("feed_mv", 32'(match_valid), 32'(exp_hit));
    if (exp_hit) chk("feed_ml", 32'(match_lane), lane);
  endtask

  task automatic clr();
    lane_valid = '1;
    lane_en    = '1;
    clear_ctx  = 1'b1;
    #1;
    chk("clr_ready", 32'(lane_ready), 0);
    @(posedge clk); #1;
    chk("clr_mv", 32'(match_valid), 0);
    clear_ctx = 1'b0;
  endtask

  initial begin
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Reset with every lane requesting: nothing may be granted.
    reset_n = 1'b0; lane_valid = '1; lane_en = '1; lane_bit = '1;
    overlap = 1'b1; clear_ctx = 1'b0;
    #1;
    chk("rst_ready", 32'(lane_ready), 0);
    @(posedge clk); #1;
    chk("rst_mv", 32'(match_valid), 0);
    chk("rst_ml", 32'(match_lane), 0);
    chk("rst_cnt", 32'(match_count), 0);
    reset_n = 1'b1;

    // Lane 0, overlapping: 1,0,1,1,0,1,1 -> hits on bits 4 and 7.
    overlap = 1'b1;
    feed(0, 1, 0); feed(0, 0, 0); feed(0, 1, 0); feed(0, 1, 1);
    feed(0, 0, 0); feed(0, 1, 0); feed(0, 1, 1);
    chk("ovl_cnt", 32'(match_count), 2);

    // Same stream, non-overlapping -> one hit.
    clr();
    overlap = 1'b0;
    feed(0, 1, 0); feed(0, 0, 0); feed(0, 1, 0); feed(0, 1, 1);
    feed(0, 0, 0); feed(0, 1, 0); feed(0, 1, 0);
    chk("novl_cnt", 32'(match_count), 3);
    chk("ml_hold", 32'(match_lane), 0);

    // One grant to lane 3 wraps the pointer back to 0.
    feed(3, 0, 0);

    // All four lanes interleave 1011; non-granted lanes see the inverse bit.
    overlap = 1'b1;
    for (int c = 0; c < 16; c++) begin
      lane_valid = '1;
      lane_en    = '1;
      lane_bit   = pat[c / 4] ? (NL'(1) << (c % 4)) : ~(NL'(1) << (c % 4));
      #1;
      chk("rr_gnt", 32'(lane_ready), 32'(1) << (c % 4));
      @(posedge clk); #1;
      chk("rr_mv", 32'(match_valid), 32'(c >= 12));
      if (c >= 12) chk("rr_ml", 32'(match_lane), c - 12);
    end
    chk("rr_cnt", 32'(match_count), 7);

    // Lane 2 reaches S3, is disabled one cycle, then restarts from S0.
    clr();
    feed(2, 1, 0); feed(2, 0, 0); feed(2, 1, 0);
    lane_valid = 4'b0100; lane_en = 4'b0000; lane_bit = 4'b0100;
    #1;
    chk("dis_ready", 32'(lane_ready), 0);
    @(posedge clk); #1;
    chk("dis_mv", 32'(match_valid), 0);
    feed(2, 1, 0);
    feed(2, 0, 0); feed(2, 1, 0); feed(2, 1, 1);
    chk("dis_cnt", 32'(match_count), 8);

    // clear_ctx while lane 1 sits in S3: following 1 must not match.
    feed(1, 1, 0); feed(1, 0, 0); feed(1, 1, 0);
    clr();
    feed(1, 1, 0);
    chk("clr_cnt", 32'(match_count), 8);

    // Saturation on lane 3: reach 14, then three more hits stay at 15.
    feed(3, 1, 0); feed(3, 0, 0); feed(3, 1, 0); feed(3, 1, 1);
    for (int m = 0; m < 5; m++) begin
      feed(3, 0, 0); feed(3, 1, 0); feed(3, 1, 1);
    end
    chk("sat_14", 32'(match_count), 14);
    for (int m = 0; m < 3; m++) begin
      feed(3, 0, 0); feed(3, 1, 0); feed(3, 1, 1);
      chk("sat_15", 32'(match_count), 15);
    end
    chk("sat_ml", 32'(match_lane), 3);

    // Mid-stream reset clears outputs; partial prefix on lane 3 is lost.
    feed(3, 0, 0); feed(3, 1, 0);
    reset_n = 1'b0; lane_valid = '1; lane_en = '1;
    #1;
    chk("rst2_ready", 32'(lane_ready), 0);
    @(posedge clk); #1;
    chk("rst2_mv", 32'(match_valid), 0);
    chk("rst2_ml", 32'(match_lane), 0);
    chk("rst2_cnt", 32'(match_count), 0);
    reset_n = 1'b1;
    feed(0, 0, 0);
    feed(3, 1, 0);
    chk("rst2_nohit_cnt", 32'(match_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
